// File: rtl/gift_encdec_control_pkg.sv
// Shared types and constants for the GIFT encrypt/decrypt sequencer.
package gift_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KEYEXP  = 3'd1,
    ST_RDSETUP = 3'd2,
    ST_ROUND   = 3'd3,
    ST_OUTWR   = 3'd4
  } ctrlState_t;

  localparam int unsigned GIFT64_ROUNDS  = 28;
  localparam int unsigned GIFT128_ROUNDS = 40;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/gift_encdec_control_if.sv
// Strobe and datapath-control bundle between the host side and the GIFT sequencer.
interface gift_encdec_control_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              inExtKeyWr;
  logic              inExtDataWr;
  logic              inMode;
  logic              outIntKeyschRegExtWr;
  logic              outIntRoundRegExtWr;
  logic              outIntKeyschRegIntWr;
  logic              outIntMemWr;
  logic              outIntMemRd;
  logic [ADDR_W-1:0] outIntMemAddr;
  logic              outIntRoundRegIntWr;
  logic              outIntDataOutRegWr;
  logic              outMode;
  logic              outBusy;
  logic              outDone;

  modport master (
    output inExtKeyWr, inExtDataWr, inMode,
    input  outIntKeyschRegExtWr, outIntRoundRegExtWr, outIntKeyschRegIntWr,
           outIntMemWr, outIntMemRd, outIntMemAddr, outIntRoundRegIntWr,
           outIntDataOutRegWr, outMode, outBusy, outDone
  );

  modport slave (
    input  inExtKeyWr, inExtDataWr, inMode,
    output outIntKeyschRegExtWr, outIntRoundRegExtWr, outIntKeyschRegIntWr,
           outIntMemWr, outIntMemRd, outIntMemAddr, outIntRoundRegIntWr,
           outIntDataOutRegWr, outMode, outBusy, outDone
  );
endinterface

// File: rtl/gift_encdec_control_addr_gen.sv
// Loadable up/down round-key memory address register; load has priority over stepping.
module gift_rk_addr_gen #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              inClk,
  input  logic              inRstN,
  input  logic              inLoad,
  input  logic [ADDR_W-1:0] inLoadVal,
  input  logic              inEn,
  input  logic              inUp,
  output logic [ADDR_W-1:0] outAddr
);

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      outAddr <= '0;
    end else if (inLoad) begin
      outAddr <= inLoadVal;
    end else if (inEn) begin
      outAddr <= inUp ? outAddr + ADDR_W'(1) : outAddr - ADDR_W'(1);
    end
  end

endmodule

// File: rtl/gift_encdec_control.sv
// GIFT encrypt/decrypt sequencer: key expansion into round-key RAM, then forward/reverse key streaming.
// Optional feature macro GIFT_KEY_CACHE_EN: reuse an already expanded key and skip KEYEXP.
module gift_encdec_control
  import gift_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS = GIFT128_ROUNDS,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  inClk,
  input  logic                  inRstN,
  gift_encdec_control_if.slave  bus
);

  localparam int unsigned       CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0]  CNT_PRELAST = CNT_W'(ROUNDS - 2);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(ROUNDS - 1);

  ctrlState_t        state, nextState;
  logic [CNT_W-1:0]  cnt;
  logic              modeQ;
  logic              cacheHit;
  logic              agLoad, agEn, agUp;
  logic [ADDR_W-1:0] agLoadVal;

`ifdef GIFT_KEY_CACHE_EN
  logic keyValid;

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      keyValid <= 1'b0;
    end else if (state == ST_IDLE && bus.inExtKeyWr) begin
      keyValid <= 1'b0;
    end else if (state == ST_KEYEXP && cnt == CNT_LAST) begin
      keyValid <= 1'b1;
    end
  end

  // A key strobe in the same cycle as the data strobe invalidates the cached schedule.
  always_comb cacheHit = keyValid && !bus.inExtKeyWr;
`else
  always_comb cacheHit = 1'b0;
`endif

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state <= ST_IDLE;
      cnt   <= '0;
      modeQ <= MODE_ENC;
    end else begin
      state <= nextState;
      if (state != nextState) begin
        cnt <= '0;
      end else if (state == ST_KEYEXP || state == ST_ROUND) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == ST_IDLE && bus.inExtDataWr) begin
        modeQ <= bus.inMode;
      end
    end
  end

  always_comb begin
    nextState                = state;
    agLoad                   = 1'b0;
    agLoadVal                = '0;
    agEn                     = 1'b0;
    agUp                     = (modeQ == MODE_ENC);
    bus.outIntKeyschRegExtWr = 1'b0;
    bus.outIntRoundRegExtWr  = 1'b0;
    bus.outIntKeyschRegIntWr = 1'b0;
    bus.outIntMemWr          = 1'b0;
    bus.outIntMemRd          = 1'b0;
    bus.outIntRoundRegIntWr  = 1'b0;
    bus.outIntDataOutRegWr   = 1'b0;
    bus.outDone              = 1'b0;
    bus.outBusy              = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        bus.outIntKeyschRegExtWr = bus.inExtKeyWr;
        bus.outIntRoundRegExtWr  = bus.inExtDataWr;
        if (bus.inExtDataWr) begin
          agLoad = 1'b1;
          if (cacheHit) begin
            nextState = ST_RDSETUP;
            agLoadVal = (bus.inMode == MODE_DEC) ? ADDR_LAST : '0;
          end else begin
            nextState = ST_KEYEXP;
          end
        end
      end
      ST_KEYEXP: begin
        bus.outIntKeyschRegIntWr = 1'b1;
        bus.outIntMemWr          = 1'b1;
        if (cnt == CNT_LAST) begin
          nextState = ST_RDSETUP;
          agLoad    = 1'b1;
          agLoadVal = (modeQ == MODE_DEC) ? ADDR_LAST : '0;
        end else begin
          agEn = 1'b1;
          agUp = 1'b1;
        end
      end
      ST_RDSETUP: begin
        bus.outIntMemRd = 1'b1;
        agEn            = 1'b1;
        nextState       = ST_ROUND;
      end
      ST_ROUND: begin
        bus.outIntMemRd         = 1'b1;
        bus.outIntRoundRegIntWr = 1'b1;
        // Address runs one ahead of the round being computed, so it parks on the final key.
        if (cnt < CNT_PRELAST) begin
          agEn = 1'b1;
        end
        if (cnt == CNT_LAST) begin
          nextState = ST_OUTWR;
        end
      end
      ST_OUTWR: begin
        bus.outIntDataOutRegWr = 1'b1;
        bus.outDone            = 1'b1;
        agLoad                 = 1'b1;
        nextState              = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb bus.outMode = modeQ;

  gift_rk_addr_gen #(
    .ADDR_W(ADDR_W)
  ) uAddrGen (
    .inClk    (inClk),
    .inRstN   (inRstN),
    .inLoad   (agLoad),
    .inLoadVal(agLoadVal),
    .inEn     (agEn),
    .inUp     (agUp),
    .outAddr  (bus.outIntMemAddr)
  );

endmodule

// File: tb/tb_gift_encdec_control.sv
// Bench for gift_encdec_control: GIFT-128 and GIFT-64 instances share stimulus, timeline model checks every cycle.
module tb_gift_encdec_control;
  import gift_ctrl_pkg::*;

  localparam int R0 = GIFT128_ROUNDS;
  localparam int R1 = GIFT64_ROUNDS;
`ifdef GIFT_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic key = 1'b0, data = 1'b0, mode = 1'b0;
  always #5 clk = ~clk;

  gift_encdec_control_if #(.ADDR_W(8)) bus0 ();
  gift_encdec_control_if #(.ADDR_W(5)) bus1 ();

  assign bus0.inExtKeyWr = key;
  assign bus0.inExtDataWr = data;
  assign bus0.inMode = mode;
  assign bus1.inExtKeyWr = key;
  assign bus1.inExtDataWr = data;
  assign bus1.inMode = mode;

  gift_encdec_control #(.ROUNDS(R0), .ADDR_W(8)) u0 (.inClk(clk), .inRstN(rstN), .bus(bus0));
  gift_encdec_control #(.ROUNDS(R1), .ADDR_W(5)) u1 (.inClk(clk), .inRstN(rstN), .bus(bus1));

  // ctl = {keyPass, dataPass, keyschInt, memWr, memRd, roundInt, dataOut, mode, busy, done}
  typedef struct packed {
    logic [9:0] ctl;
    logic [7:0] addr;
  } outs_t;

  typedef struct {
    bit key;
    bit data;
    bit expKp;
    bit expDp;
  } vec_t;

  int tests = 0, errors = 0;
  int cyc = 0;
  int rounds[2];
  bit mAct[2], mMode[2], mSkip[2], mKv[2];
  int mJ[2];
  int lastDone[2], doneTot[2], busyTot[2], wrTot[2];

  function automatic outs_t getAct(int d);
    outs_t o;
    if (d == 0)
      o.ctl = {bus0.outIntKeyschRegExtWr, bus0.outIntRoundRegExtWr, bus0.outIntKeyschRegIntWr,
               bus0.outIntMemWr, bus0.outIntMemRd, bus0.outIntRoundRegIntWr, bus0.outIntDataOutRegWr,
               bus0.outMode, bus0.outBusy, bus0.outDone};
    else
      o.ctl = {bus1.outIntKeyschRegExtWr, bus1.outIntRoundRegExtWr, bus1.outIntKeyschRegIntWr,
               bus1.outIntMemWr, bus1.outIntMemRd, bus1.outIntRoundRegIntWr, bus1.outIntDataOutRegWr,
               bus1.outMode, bus1.outBusy, bus1.outDone};
    o.addr = (d == 0) ? bus0.outIntMemAddr : {3'b000, bus1.outIntMemAddr};
    return o;
  endfunction

  // Expected outputs from the operation timeline: j = cycles since the accepting edge.
  function automatic outs_t expOut(int r, bit act, int j, bit md, bit skip, bit k, bit dw,
                                   output bit addrCare);
    outs_t e;
    int kx, rr;
    e = '0;
    addrCare = 1'b1;
    e.ctl[2] = md;
    if (!act) begin
      e.ctl[9] = k;
      e.ctl[8] = dw;
    end else begin
      e.ctl[1] = 1'b1;
      kx = skip ? 0 : r;
      if (j < kx) begin
        e.ctl[7] = 1'b1;
        e.ctl[6] = 1'b1;
        e.addr = 8'(j);
      end else if (j == kx) begin
        e.ctl[5] = 1'b1;
        e.addr = md ? 8'(r - 1) : 8'd0;
      end else if (j <= kx + r) begin
        rr = j - kx;
        if (rr > r - 1) rr = r - 1;
        e.ctl[5] = 1'b1;
        e.ctl[4] = 1'b1;
        e.addr = md ? 8'(r - 1 - rr) : 8'(rr);
      end else begin
        e.ctl[3] = 1'b1;
        e.ctl[0] = 1'b1;
        addrCare = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic check(string name, int got, int want);
    tests++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic modelCycle();
    outs_t a, e;
    bit care;
    int kx;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rstN) begin
        mAct[d] = 1'b0; mJ[d] = 0; mMode[d] = 1'b0; mSkip[d] = 1'b0; mKv[d] = 1'b0;
      end
      a = getAct(d);
      e = expOut(rounds[d], mAct[d], mJ[d], mMode[d], mSkip[d], key, data, care);
      tests++;
      if (a.ctl != e.ctl || (care && a.addr != e.addr)) begin
        errors++;
        $display("FAIL model dut%0d cyc %0d j %0d: got ctl %b addr %0d, want ctl %b addr %0d",
                 d, cyc, mJ[d], a.ctl, a.addr, e.ctl, e.addr);
      end
      if (a.ctl[3]) lastDone[d] = cyc;
      doneTot[d] += int'(a.ctl[0]);
      busyTot[d] += int'(a.ctl[1]);
      wrTot[d] += int'(a.ctl[6]);
      if (rstN) begin
        if (!mAct[d]) begin
          if (data) begin
            mAct[d] = 1'b1; mJ[d] = 0; mMode[d] = mode;
            mSkip[d] = CACHE_EN && mKv[d] && !key;
          end
          if (key) mKv[d] = 1'b0;
        end else begin
          kx = mSkip[d] ? 0 : rounds[d];
          if (CACHE_EN && !mSkip[d] && mJ[d] == rounds[d] - 1) mKv[d] = 1'b1;
          mJ[d]++;
          if (mJ[d] > kx + rounds[d] + 1) mAct[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    modelCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(int budget);
    int n = 0;
    while ((bus0.outBusy || bus1.outBusy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("idle timeout", n, -1);
  endtask

  task automatic runOp(string name, bit md, bit withKey, bit same, bit inject, bit expSkip);
    int sc, d0[2], b0[2], w0[2], lat;
    if (withKey && !same) begin
      key = 1'b1; tick(); key = 1'b0;
    end
    data = 1'b1; key = same; mode = md;
    tick();
    data = 1'b0; key = 1'b0;
    sc = cyc;
    for (int d = 0; d < 2; d++) begin
      d0[d] = doneTot[d]; b0[d] = busyTot[d]; w0[d] = wrTot[d]; lastDone[d] = 0;
    end
    if (inject) begin
      repeat (5) tick();
      data = 1'b1; key = 1'b1; mode = ~md;
      tick();
      data = 1'b0; key = 1'b0; mode = md;
      repeat (18) tick();
      key = 1'b1; tick(); key = 1'b0;
    end
    waitIdle(300);
    tick();
    for (int d = 0; d < 2; d++) begin
      lat = expSkip ? rounds[d] + 2 : 2 * rounds[d] + 2;
      check($sformatf("%s dut%0d latency", name, d), lastDone[d] - sc, lat);
      check($sformatf("%s dut%0d done pulses", name, d), doneTot[d] - d0[d], 1);
      check($sformatf("%s dut%0d busy cycles", name, d), busyTot[d] - b0[d], lat);
      check($sformatf("%s dut%0d memWr cycles", name, d), wrTot[d] - w0[d], expSkip ? 0 : rounds[d]);
    end
  endtask

  initial begin
    vec_t vecs[4];
    outs_t a;
    rounds[0] = R0;
    rounds[1] = R1;
    vecs[0] = '{key: 1'b0, data: 1'b0, expKp: 1'b0, expDp: 1'b0};
    vecs[1] = '{key: 1'b1, data: 1'b0, expKp: 1'b1, expDp: 1'b0};
    vecs[2] = '{key: 1'b0, data: 1'b1, expKp: 1'b0, expDp: 1'b1};
    vecs[3] = '{key: 1'b1, data: 1'b1, expKp: 1'b1, expDp: 1'b1};

    repeat (2) tick();
    rstN = 1'b1;
    tick();

    // Idle pass-through, applied and withdrawn between edges.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      key = vecs[i].key; data = vecs[i].data;
      #1;
      for (int d = 0; d < 2; d++) begin
        a = getAct(d);
        check($sformatf("vec%0d dut%0d keyPass", i, d), int'(a.ctl[9]), int'(vecs[i].expKp));
        check($sformatf("vec%0d dut%0d dataPass", i, d), int'(a.ctl[8]), int'(vecs[i].expDp));
        check($sformatf("vec%0d dut%0d busy", i, d), int'(a.ctl[1]), 0);
      end
      key = 1'b0; data = 1'b0;
      #1;
    end
    @(posedge clk);
    #1;

    runOp("dec key+data", MODE_DEC, 1'b1, 1'b0, 1'b0, 1'b0);
    runOp("enc no key", MODE_ENC, 1'b0, 1'b0, 1'b0, CACHE_EN);
    runOp("enc new key", MODE_ENC, 1'b1, 1'b0, 1'b0, 1'b0);
    runOp("dec busy strobes", MODE_DEC, 1'b0, 1'b0, 1'b1, CACHE_EN);
    runOp("same-cycle key+data", MODE_ENC, 1'b1, 1'b1, 1'b0, 1'b0);

    // Back-to-back: data strobe right in the cycle after OUTWR.
    data = 1'b1; mode = MODE_DEC;
    tick();
    data = 1'b0;
    waitIdle(300);
    while (bus0.outBusy == 1'b0 && bus1.outBusy == 1'b0 && !bus0.outIntDataOutRegWr) begin
      data = 1'b1; tick(); data = 1'b0;
      break;
    end
    waitIdle(300);

    // Reset in the middle of ROUND, then a data-only operation must expand again.
    data = 1'b1; mode = MODE_DEC;
    tick();
    data = 1'b0;
    repeat (CACHE_EN ? 15 : 50) tick();
    check("pre-reset dut0 in ROUND", int'(bus0.outIntRoundRegIntWr), 1);
    check("pre-reset dut1 in ROUND", int'(bus1.outIntRoundRegIntWr), 1);
    rstN = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      a = getAct(d);
      check($sformatf("reset dut%0d ctl", d), int'(a.ctl), 0);
      check($sformatf("reset dut%0d addr", d), int'(a.addr), 0);
    end
    tick();
    rstN = 1'b1;
    tick();
    runOp("after reset", MODE_ENC, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      key = ($urandom % 10) == 0;
      data = ($urandom % 7) == 0;
      mode = 1'($urandom % 2);
      rstN = ($urandom % 600) != 0;
      tick();
    end
    key = 1'b0; data = 1'b0; rstN = 1'b1;
    waitIdle(300);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
